// File: rtl/adder_pkg.sv
// adder_pkg: FSM state codes and digit width shared by the serial adder files
package adder_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int DIGIT_W = 2;
endpackage

// File: rtl/adder_slice_2bit.sv
// adder_slice_2bit: combinational 2-bit full adder producing one digit and its carry
module adder_slice_2bit
  import adder_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands one 2-bit digit per cycle, LSB first
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int N = WIDTH / DIGIT_W;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  logic [1:0] state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0] cnt;
  logic carry_reg, s_carry, last;
  logic [DIGIT_W-1:0] s_sum;
  adder_slice_2bit u_slice (
    .a(a_sh[DIGIT_W-1:0]),
    .b(b_sh[DIGIT_W-1:0]),
    .cin(carry_reg),
    .sum(s_sum),
    .carry(s_carry)
  );
  assign last = cnt == CW'(N - 1);
  always_comb begin
    state_nx = state == S_IDLE ? (start ? S_ADD : S_IDLE) :
               state == S_ADD  ? (last ? S_DONE : S_ADD) : S_IDLE;
    ready = state == S_IDLE;
    busy = state == S_ADD || state == S_DONE;
    done = state == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_sh <= '0;
      b_sh <= '0;
      cnt <= '0;
      carry_reg <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        a_sh <= a;
        b_sh <= b;
        carry_reg <= cin;
        cnt <= '0;
      end else if (state == S_ADD) begin
        sum[DIGIT_W*cnt +: DIGIT_W] <= s_sum;
        a_sh <= a_sh >> DIGIT_W;
        b_sh <= b_sh >> DIGIT_W;
        carry_reg <= s_carry;
        cnt <= last ? cnt : cnt + CW'(1);
        if (last) cout <= s_carry;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: WIDTH 2/8/16 instances driven together against a cycle-count reference model
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst, start, cin;
  logic [15:0] a, b;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  for (genvar i = 0; i < 3; i++) begin : gw
    localparam int W = i == 0 ? 2 : i == 1 ? 8 : 16;
    logic ready, busy, done, cout;
    logic [W-1:0] sum;
    int phase = 0;
    logic [W:0] res = '0;
    serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .a(a[W-1:0]),
      .b(b[W-1:0]),
      .cin(cin),
      .ready(ready),
      .busy(busy),
      .done(done),
      .sum(sum),
      .cout(cout)
    );
    // phase counts cycles left until idle: N+1 after acceptance, 1 means the done cycle
    always @(posedge clk)
      if (rst) begin
        phase <= 0;
        res <= '0;
      end else if (phase == 0 && start) begin
        res <= (W+1)'(a[W-1:0]) + (W+1)'(b[W-1:0]) + (W+1)'(cin);
        phase <= W / 2 + 1;
      end else if (phase > 0) phase <= phase - 1;
    always @(negedge clk)
      if (chk_en) begin
        chk($sformatf("w%0d_ready", W), ready, phase == 0);
        chk($sformatf("w%0d_busy", W), busy, phase != 0);
        chk($sformatf("w%0d_done", W), done, phase == 1);
        if (phase <= 1) begin
          chk($sformatf("w%0d_sum", W), sum, res[W-1:0]);
          chk($sformatf("w%0d_cout", W), cout, res[W]);
        end
      end
  end
  initial begin
    int n, d;
    rst = 1'b1;
    start = 1'b0;
    cin = 1'b0;
    a = '0;
    b = '0;
    step(2);
    chk_en = 1'b1;
    rst = 1'b0;
    step(1);
    chk("rst_sum", gw[1].sum, 32'h0);
    chk("rst_ready", gw[1].ready, 32'h1);
    a = 16'h005A;
    b = 16'h003C;
    start = 1'b1;
    step(1);
    start = 1'b0;
    n = 0;
    while (!gw[1].done && n < 20) begin
      step(1);
      n++;
    end
    chk("t1_latency", n, 32'd4);
    chk("t1_sum", gw[1].sum, 32'h96);
    chk("t1_cout", gw[1].cout, 32'h0);
    step(12);
    a = 16'h00FF;
    b = 16'h0001;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(12);
    chk("t2a_sum", gw[1].sum, 32'h00);
    chk("t2a_cout", gw[1].cout, 32'h1);
    a = 16'h00FF;
    b = 16'h00FF;
    cin = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    cin = 1'b0;
    step(12);
    chk("t2b_sum", gw[1].sum, 32'hFF);
    chk("t2b_cout", gw[1].cout, 32'h1);
    d = 0;
    start = 1'b1;
    repeat (36) begin
      a = 16'($urandom);
      b = 16'($urandom);
      step(1);
      d += int'(gw[1].done);
    end
    start = 1'b0;
    chk("t3_ops", d, 32'd6);
    step(12);
    a = 16'h0012;
    b = 16'h0034;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t4_ready", gw[1].ready, 32'h1);
    chk("t4_sum", gw[1].sum, 32'h0);
    d = 0;
    repeat (10) begin
      step(1);
      d += int'(gw[1].done);
    end
    chk("t4_nodone", d, 32'd0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(12);
    chk("t4_sum2", gw[1].sum, 32'h46);
    rst = 1'b1;
    start = 1'b1;
    step(1);
    rst = 1'b0;
    start = 1'b0;
    d = 0;
    repeat (10) begin
      step(1);
      d += int'(gw[1].done) + int'(gw[2].done) + int'(gw[0].done);
    end
    chk("t5_nodone", d, 32'd0);
    repeat (13000) begin
      start = $urandom_range(0, 3) != 0;
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      rst = $urandom_range(0, 299) == 0;
      step(1);
    end
    rst = 1'b0;
    start = 1'b0;
    step(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
